serial_addsub: RTL

- Bit-serial adder/subtractor, the sequential stage that drives the team's 1-bit full adder / full subtractor cells.
- A WIDTH-bit operation is accepted with a start/busy/done handshake.
- Operands are fed LSB-first through one full-adder / full-subtractor slice, one bit per clock, with a registered carry/borrow.
- Produces the WIDTH-bit result, the final carry/borrow, and signed overflow.

---
 rtl/serial_addsub.sv | 90 +++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, one full-add/full-sub slice per clock, LSB first
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] acc;
    logic             c;
    logic             mode_r;
    logic [CW-1:0]    count;
    logic             s;
    logic             c_next;

    // One slice: sum/difference bit is identical; only carry vs borrow differs.
    always_comb begin
        s = sa[0] ^ sb[0] ^ c;
        if (mode_r)
            c_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & c);
        else
            c_next = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            c      <= 1'b0;
            mode_r <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        mode_r <= mode;
                        c      <= 1'b0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    // acc keeps the low WIDTH-1 result bits; the MSB comes straight from the slice.
                    acc   <= (WIDTH-1)'({s, acc} >> 1);
                    c     <= c_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= {s, acc};
                        cout   <= c_next;
                        ovf    <= c ^ c_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
